seg7_display_scheduler: RTL

Scan controller and arbiter for the Basys3 four-digit 7-segment display. It time-multiplexes the four digits with a parameterized refresh prescaler. It shares the display between a continuous result source (the ALSU output) and a one-shot alert source (error codes such as "E404"); alerts take priority for a fixed hold time. Displayed data is latched only at frame boundaries, so a digit never shows a mix of old and new values.

---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/hex_to_seg7.sv | 30 +++
 rtl/seg7_display_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns, anode selects and scheduler state type
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESULT = 2'd1,
        ALERT  = 2'd2
    } state_t;

    // Active-low cathodes, {a,b,c,d,e,f,g} with a in the MSB
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = AN_DIG0;
            2'd1:    an = AN_DIG1;
            2'd2:    an = AN_DIG2;
            default: an = AN_DIG3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - hex nibble to active-low 7-segment cathode pattern
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_display_scheduler.sv
// rtl/seg7_display_scheduler.sv - 4-digit scan controller arbitrating result and alert sources
module seg7_display_scheduler
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        res_valid,
    input  logic [15:0] res_data,
    input  logic [3:0]  res_blank,
    input  logic        alert_req,
    input  logic [15:0] alert_data,
    output logic        alert_ack,
    output logic [3:0]  Anode_Activate,
    output logic [6:0]  LED_out,
    output logic        dp,
    output logic        frame_tick,
    output logic        showing_alert
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic [PW-1:0] prescaler, nxt_pre;
    logic [1:0]    idx, nxt_idx;
    state_t        state, nxt_state;
    logic [HW-1:0] hold, nxt_hold;
    logic [15:0]   shadow_data, nxt_data;
    logic [3:0]    shadow_blank, nxt_blank;
    logic          slot_end, boundary, accept;

    logic [3:0]    nibble;
    logic [6:0]    hex_seg;
    logic [3:0]    an_d;
    logic [6:0]    led_d;
    logic          dp_d;

    assign slot_end = (prescaler == PRE_LAST);
    assign boundary = slot_end && (idx == 2'd3);

    // Arbitration happens only on the frame boundary so a frame is never torn
    always_comb begin
        nxt_pre   = slot_end ? '0 : prescaler + 1'b1;
        nxt_idx   = slot_end ? idx + 2'd1 : idx;
        nxt_state = state;
        nxt_hold  = hold;
        nxt_data  = shadow_data;
        nxt_blank = shadow_blank;
        accept    = 1'b0;
        if (boundary) begin
            if (state == ALERT && hold > HOLD_ONE) begin
                nxt_hold = hold - 1'b1;
            end else if (alert_req) begin
                accept    = 1'b1;
                nxt_state = ALERT;
                nxt_hold  = HOLD_LOAD;
                nxt_data  = alert_data;
                nxt_blank = '0;
            end else if (res_valid) begin
                nxt_state = RESULT;
                nxt_hold  = '0;
                nxt_data  = res_data;
                nxt_blank = res_blank;
            end else begin
                nxt_state = IDLE;
                nxt_hold  = '0;
            end
        end
    end

    // Outputs are decoded from next-state values so they land one cycle after the decision
    assign nibble = nxt_data[{nxt_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_comb begin
        an_d  = anode_sel(nxt_idx);
        led_d = hex_seg;
        dp_d  = 1'b1;
        case (nxt_state)
            IDLE: begin
                led_d = SEG_DASH;
            end
            RESULT: begin
                if (nxt_blank[nxt_idx]) begin
                    an_d  = AN_OFF;
                    led_d = SEG_BLANK;
                end
            end
            ALERT: begin
                dp_d = (nxt_idx != 2'd3);
            end
            default: begin
                led_d = SEG_DASH;
            end
        endcase
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            prescaler      <= '0;
            idx            <= 2'd0;
            state          <= IDLE;
            hold           <= '0;
            shadow_data    <= '0;
            shadow_blank   <= '0;
            Anode_Activate <= AN_DIG0;
            LED_out        <= SEG_DASH;
            dp             <= 1'b1;
            alert_ack      <= 1'b0;
            frame_tick     <= 1'b0;
            showing_alert  <= 1'b0;
        end else begin
            prescaler      <= nxt_pre;
            idx            <= nxt_idx;
            state          <= nxt_state;
            hold           <= nxt_hold;
            shadow_data    <= nxt_data;
            shadow_blank   <= nxt_blank;
            Anode_Activate <= an_d;
            LED_out        <= led_d;
            dp             <= dp_d;
            alert_ack      <= accept;
            frame_tick     <= boundary;
            showing_alert  <= (nxt_state == ALERT);
        end
    end

endmodule
